// File: rtl/ecc_des_host_seq.sv
// rtl/ecc_des_host_seq.sv - host-side ECC/DES start/done command sequencer
//
// Purpose: accepts one host command at a time and drives the controller start
// protocol. It raises ecc_start1, ecc_start2 or des_start. It then waits for the
// matching done, captures the ECC1 public key and counts DES blocks. It returns
// a one-cycle response with an error flag.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_op, cmd_blocks        opcode (00 ECC1, 01 ECC2, 10 DES, 11 illegal), DES block count
//   ecc_start1/2, des_start   start requests to the controller
//   ecc1_done/ecc2_done       ECC completion pulses from the controller
//   des_done                  DES block-completion indication
//   PuX, PuY                  controller public key, valid with ecc1_done
//   pub_x, pub_y, pub_valid   captured public key and its valid flag
//   blk_tick                  one pulse per counted DES block
//   resp_valid/err/op         one-cycle command completion response
module ecc_des_host_seq #(
  parameter int ECC_TIMEOUT = 1000000,
  parameter int DRAIN_CYC   = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [7:0]   cmd_blocks,
  output logic         ecc_start1,
  output logic         ecc_start2,
  output logic         des_start,
  input  logic         ecc1_done,
  input  logic         ecc2_done,
  input  logic         des_done,
  input  logic [163:0] PuX,
  input  logic [163:0] PuY,
  output logic [163:0] pub_x,
  output logic [163:0] pub_y,
  output logic         pub_valid,
  output logic         blk_tick,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [1:0]   resp_op
);

  typedef enum logic [2:0] {
    IDLE,
    ECC_REQ,
    ECC_WAIT,
    DES_RUN,
    DES_DRAIN,
    RESP
  } state_t;

  localparam logic [1:0]  OP_ECC1 = 2'b00;
  localparam logic [1:0]  OP_ECC2 = 2'b01;
  localparam logic [1:0]  OP_DES  = 2'b10;
  localparam logic [19:0] TIMEOUT_LAST = 20'(ECC_TIMEOUT - 1);
  localparam logic [19:0] DRAIN_LAST   = 20'(DRAIN_CYC - 1);

  state_t      state, state_nx;
  logic [1:0]  op_q;
  logic [7:0]  blocks_q;
  logic [7:0]  cnt_q;
  // Shared timer: ECC timeout in ECC_WAIT, drain length in DES_DRAIN.
  logic [19:0] timer_q;
  logic        err_q, err_nx;

  logic accept;
  logic done_match;
  logic des_last;

  assign accept     = cmd_valid && cmd_ready;
  assign done_match = (op_q == OP_ECC1) ? ecc1_done : ecc2_done;
  assign des_last   = des_done && ((cnt_q + 8'd1) == blocks_q);

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          err_nx = 1'b0;
          case (cmd_op)
            OP_ECC1, OP_ECC2: state_nx = ECC_REQ;
            OP_DES: begin
              if (cmd_blocks != 8'd0) begin
                state_nx = DES_RUN;
              end else begin
                state_nx = RESP;
                err_nx   = 1'b1;
              end
            end
            default: begin
              state_nx = RESP;
              err_nx   = 1'b1;
            end
          endcase
        end
      end
      ECC_REQ: state_nx = ECC_WAIT;
      ECC_WAIT: begin
        // A done in the timeout cycle still counts as success.
        if (done_match) begin
          state_nx = RESP;
          err_nx   = 1'b0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end
      end
      DES_RUN: begin
        if (des_last) state_nx = DES_DRAIN;
      end
      DES_DRAIN: begin
        if (timer_q == DRAIN_LAST) begin
          state_nx = RESP;
          err_nx   = 1'b0;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      blocks_q  <= 8'd0;
      cnt_q     <= 8'd0;
      timer_q   <= 20'd0;
      err_q     <= 1'b0;
      pub_x     <= '0;
      pub_y     <= '0;
      pub_valid <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            blocks_q <= cmd_blocks;
            cnt_q    <= 8'd0;
            timer_q  <= 20'd0;
            if (cmd_op == OP_ECC1) pub_valid <= 1'b0;
          end
        end
        ECC_WAIT: begin
          timer_q <= timer_q + 20'd1;
          if (op_q == OP_ECC1 && ecc1_done) begin
            pub_x     <= PuX;
            pub_y     <= PuY;
            pub_valid <= 1'b1;
          end
        end
        DES_RUN: begin
          if (des_done) cnt_q <= cnt_q + 8'd1;
          // Restart the timer so it measures the drain period.
          if (des_last) timer_q <= 20'd0;
        end
        DES_DRAIN: timer_q <= timer_q + 20'd1;
        default: ;
      endcase
    end
  end

  // While rst is still held, the sequencer does not advertise readiness.
  assign cmd_ready  = (state == IDLE) && !rst;
  assign ecc_start1 = (state == ECC_REQ) && (op_q == OP_ECC1);
  assign ecc_start2 = (state == ECC_REQ) && (op_q == OP_ECC2);
  assign des_start  = (state == DES_RUN);
  assign blk_tick   = (state == DES_RUN) && des_done;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_op    = resp_valid ? op_q : 2'b00;

endmodule

// File: tb/tb_ecc_des_host_seq.sv
// tb/tb_ecc_des_host_seq.sv - directed self-checking bench for ecc_des_host_seq
module tb_ecc_des_host_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_blocks;
  logic         ecc_start1, ecc_start2, des_start;
  logic         ecc1_done, ecc2_done, des_done;
  logic [163:0] PuX, PuY;
  logic [163:0] pub_x, pub_y;
  logic         pub_valid, blk_tick;
  logic         resp_valid, resp_err;
  logic [1:0]   resp_op;

  int total = 0;
  int bad   = 0;

  localparam logic [163:0] KEY_X  = 164'h1234_5678_9ABC_DEF0_1122_3344_5566_7788_99AA_BBCC_D;
  localparam logic [163:0] KEY_Y  = 164'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01_2;
  localparam logic [163:0] KEY_X2 = 164'h5;
  localparam logic [163:0] KEY_Y2 = 164'h6;

  always #5 clk = ~clk;

  ecc_des_host_seq #(.ECC_TIMEOUT(20), .DRAIN_CYC(48)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_blocks(cmd_blocks),
    .ecc_start1(ecc_start1), .ecc_start2(ecc_start2), .des_start(des_start),
    .ecc1_done(ecc1_done), .ecc2_done(ecc2_done), .des_done(des_done),
    .PuX(PuX), .PuY(PuY),
    .pub_x(pub_x), .pub_y(pub_y), .pub_valid(pub_valid),
    .blk_tick(blk_tick),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_op(resp_op)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [163:0] obs, input logic [163:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_blocks = 8'd0;
    ecc1_done = 1'b0; ecc2_done = 1'b0; des_done = 1'b0;
    PuX = '0; PuY = '0;

    // reset state
    step(); step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_pub_valid", pub_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_pub_x", pub_x, 0);
    rst = 1'b0; #1;
    check("ready_after_rst", cmd_ready, 1);

    // op 00, done 10 cycles after start
    cmd_valid = 1'b1; cmd_op = 2'b00;
    step();
    cmd_valid = 1'b0;
    check("e1_start", ecc_start1, 1);
    check("e1_start2_low", ecc_start2, 0);
    check("e1_busy", cmd_ready, 0);
    step();
    repeat (9) begin
      check("e1_start_drop", ecc_start1, 0);
      check("e1_busy_wait", cmd_ready, 0);
      check("e1_no_resp", resp_valid, 0);
      step();
    end
    ecc1_done = 1'b1; PuX = KEY_X; PuY = KEY_Y;
    step();
    ecc1_done = 1'b0; PuX = '0; PuY = '0;
    check("e1_resp", resp_valid, 1);
    check("e1_err", resp_err, 0);
    check("e1_op", resp_op, 2'b00);
    check("e1_pub_valid", pub_valid, 1);
    check("e1_pub_x", pub_x, KEY_X);
    check("e1_pub_y", pub_y, KEY_Y);
    check("e1_busy_resp", cmd_ready, 0);
    step();
    check("e1_resp_once", resp_valid, 0);
    check("e1_idle_ready", cmd_ready, 1);

    // op 01 with a stray ecc1_done
    cmd_valid = 1'b1; cmd_op = 2'b01;
    step();
    cmd_valid = 1'b0;
    check("e2_start", ecc_start2, 1);
    check("e2_start1_low", ecc_start1, 0);
    step();
    ecc1_done = 1'b1; PuX = 164'hDEAD; PuY = 164'hBEEF;
    step();
    ecc1_done = 1'b0; PuX = '0; PuY = '0;
    check("e2_stray_ignored", resp_valid, 0);
    step(); step();
    ecc2_done = 1'b1;
    step();
    ecc2_done = 1'b0;
    check("e2_resp", resp_valid, 1);
    check("e2_err", resp_err, 0);
    check("e2_op", resp_op, 2'b01);
    check("e2_pub_x_kept", pub_x, KEY_X);
    check("e2_pub_valid_kept", pub_valid, 1);
    step();

    // op 10, three blocks
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_blocks = 8'd3;
    step();
    cmd_valid = 1'b0;
    check("des_start_on", des_start, 1);
    check("des_no_tick", blk_tick, 0);
    for (int b = 0; b < 3; b++) begin
      des_done = 1'b1; #1;
      check("des_tick", blk_tick, 1);
      step();
      des_done = 1'b0;
      if (b < 2) begin
        check("des_still_run", des_start, 1);
        step();
      end
    end
    check("des_start_drop", des_start, 0);
    des_done = 1'b1; #1;
    check("drain_no_tick", blk_tick, 0);
    des_done = 1'b0;
    n = 1;
    while (!resp_valid && n < 200) begin
      step();
      n++;
    end
    check("des_resp_delay", n, 49);
    check("des_err", resp_err, 0);
    check("des_op", resp_op, 2'b10);
    step();

    // op 10 with zero blocks
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_blocks = 8'd0;
    step();
    cmd_valid = 1'b0;
    check("zb_resp", resp_valid, 1);
    check("zb_err", resp_err, 1);
    check("zb_op", resp_op, 2'b10);
    check("zb_no_des", des_start, 0);
    step();

    // illegal op 11
    cmd_valid = 1'b1; cmd_op = 2'b11;
    step();
    cmd_valid = 1'b0;
    check("ill_resp", resp_valid, 1);
    check("ill_err", resp_err, 1);
    check("ill_op", resp_op, 2'b11);
    check("ill_no_starts", {ecc_start1, ecc_start2, des_start}, 0);
    step();

    // op 00 timeout (ECC_TIMEOUT = 20)
    cmd_valid = 1'b1; cmd_op = 2'b00;
    step();
    cmd_valid = 1'b0;
    check("to_start", ecc_start1, 1);
    check("to_pub_cleared", pub_valid, 0);
    step();
    n = 1;
    while (!resp_valid && n < 100) begin
      check("to_start_low", ecc_start1, 0);
      step();
      n++;
    end
    check("to_resp_delay", n, 21);
    check("to_err", resp_err, 1);
    check("to_op", resp_op, 2'b00);
    check("to_pub_valid", pub_valid, 0);
    check("to_pub_x_kept", pub_x, KEY_X);
    step();

    // reset mid DES_RUN
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_blocks = 8'd5;
    step();
    cmd_valid = 1'b0;
    repeat (2) begin
      des_done = 1'b1;
      step();
      des_done = 1'b0;
      step();
    end
    check("mid_des_running", des_start, 1);
    rst = 1'b1;
    step();
    check("mid_des_drop", des_start, 0);
    check("mid_no_resp", resp_valid, 0);
    rst = 1'b0; #1;
    check("mid_ready", cmd_ready, 1);
    check("mid_pub_cleared", pub_valid, 0);
    repeat (3) begin
      step();
      check("mid_no_resp_later", resp_valid, 0);
    end

    // new op 00 completes normally
    cmd_valid = 1'b1; cmd_op = 2'b00;
    step();
    cmd_valid = 1'b0;
    check("re_start", ecc_start1, 1);
    step(); step();
    ecc1_done = 1'b1; PuX = KEY_X2; PuY = KEY_Y2;
    step();
    ecc1_done = 1'b0;
    check("re_resp", resp_valid, 1);
    check("re_err", resp_err, 0);
    check("re_pub_x", pub_x, KEY_X2);
    check("re_pub_y", pub_y, KEY_Y2);
    check("re_pub_valid", pub_valid, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
